// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the dmem arbiter: FSM state encoding and dmem write-enable levels.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_STALL = 2'b10
  } arb_state_e;

  localparam logic DM_RD = 1'b0;
  localparam logic DM_WR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_tag_pipe.sv
// Read-return tag delay line: DEPTH cycles, 1 bit wide, cleared by synchronous reset.
// No backpressure; one tag enters and one leaves every cycle.
module arb_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem between the cpu (zero latency, priority) and an ext req/gnt port.
// Ext reads return RD_LAT cycles after gnt; a starving ext port raises stall_req for one slot.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 21,
  parameter int DATA_W       = 128,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memEn,
  input  logic              cpu_memWrEn,
  input  logic [ADDR_W-1:0] cpu_memAddr,
  input  logic [DATA_W-1:0] cpu_dataOut,
  output logic [DATA_W-1:0] cpu_dataIn,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              stall_req,
  output logic              dm_en,
  output logic              dm_wren,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             cpu_sel, ext_sel;
  logic             tag_out;

  // A stalled pipeline re-presents its access next cycle, so the cpu is simply ignored here.
  assign cpu_sel = ~reset & cpu_memEn & ~stall_q;
  assign ext_sel = ~reset & ext_req & ~cpu_sel;

  always_comb begin
    dm_en    = 1'b0;
    dm_wren  = DM_RD;
    dm_addr  = cpu_memAddr;
    dm_wdata = cpu_dataOut;
    if (cpu_sel) begin
      dm_en   = 1'b1;
      dm_wren = cpu_memWrEn ? DM_WR : DM_RD;
    end else if (ext_sel) begin
      dm_en    = 1'b1;
      dm_wren  = ext_we ? DM_WR : DM_RD;
      dm_addr  = ext_addr;
      dm_wdata = ext_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ext_req & ~ext_sel) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (~ext_req | ext_sel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
          state_d = ST_STALL;
          cnt_d   = cnt_q + CNT_W'(1);
          stall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The cpu is blocked here, so a held request is always granted; a dropped one just ends.
      ST_STALL: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  arb_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .din  (ext_sel & ~ext_we),
    .dout (tag_out)
  );

  assign ext_gnt    = ext_sel;
  assign ext_rvalid = tag_out & ~reset;
  assign ext_rdata  = dm_rdata;
  assign cpu_dataIn = dm_rdata;
  assign stall_req  = stall_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a denial-count / grant-schedule model.
module tb_dmem_arbiter;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 128;
  localparam int RD_LAT = 2;
  localparam int LIMIT  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_memEn, cpu_memWrEn;
  logic [ADDR_W-1:0] cpu_memAddr;
  logic [DATA_W-1:0] cpu_dataOut, cpu_dataIn;
  logic              ext_req, ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic              ext_gnt, ext_rvalid, stall_req;
  logic              dm_en, dm_wren;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_memEn(cpu_memEn), .cpu_memWrEn(cpu_memWrEn), .cpu_memAddr(cpu_memAddr),
    .cpu_dataOut(cpu_dataOut), .cpu_dataIn(cpu_dataIn),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .stall_req(stall_req),
    .dm_en(dm_en), .dm_wren(dm_wren), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  // Environment memory (driven from the DUT pins) and reference memory (driven by the model).
  logic [DATA_W-1:0] env_mem [256];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  assign dm_rdata = rd_pipe[RD_LAT-1];

  int                n_cmp = 0;
  int                n_mis = 0;
  int                cyc = 0;
  int                denied = 0;
  logic              stall_e = 1'b0;
  logic              gnt_e = 1'b0;
  logic              rv_sched [8];
  logic [DATA_W-1:0] rd_sched [8];
  logic              obs_gnt, obs_stall, obs_rv;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic cs, rv;
    int   slot;
    @(negedge clk);
    cs    = ~reset & cpu_memEn & ~stall_e;
    gnt_e = ~reset & ext_req & ~cs;
    slot  = cyc % 8;
    check_eq("stall_req", stall_req, stall_e);
    check_eq("dm_en", dm_en, cs | gnt_e);
    check_eq("ext_gnt", ext_gnt, gnt_e);
    if (cs | gnt_e) begin
      check_eq("dm_wren", dm_wren, cs ? cpu_memWrEn : ext_we);
      check_eq("dm_addr", dm_addr, cs ? cpu_memAddr : ext_addr);
      if (cs ? cpu_memWrEn : ext_we)
        check_eq("dm_wdata", dm_wdata, cs ? cpu_dataOut : ext_wdata);
    end
    rv = ~reset & rv_sched[slot];
    check_eq("ext_rvalid", ext_rvalid, rv);
    if (rv) check_eq("ext_rdata", ext_rdata, rd_sched[slot]);
    obs_gnt   = ext_gnt;
    obs_stall = stall_req;
    obs_rv    = ext_rvalid;

    if (dm_en & dm_wren) env_mem[dm_addr[7:0]] = dm_wdata;
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = env_mem[dm_addr[7:0]];

    rv_sched[slot] = 1'b0;
    if (reset) begin
      for (int i = 0; i < 8; i++) rv_sched[i] = 1'b0;
      denied  = 0;
      stall_e = 1'b0;
    end else begin
      if (gnt_e & ~ext_we) begin
        rv_sched[(cyc + RD_LAT) % 8] = 1'b1;
        rd_sched[(cyc + RD_LAT) % 8] = ref_mem[ext_addr[7:0]];
      end
      if (cs & cpu_memWrEn) ref_mem[cpu_memAddr[7:0]] = cpu_dataOut;
      if (gnt_e & ext_we)   ref_mem[ext_addr[7:0]]    = ext_wdata;
      // A request denied LIMIT times in a row forces one stall slot.
      if (ext_req & ~gnt_e) denied++;
      else                  denied = 0;
      stall_e = (denied == LIMIT);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic en, input logic we, input int addr);
    cpu_memEn   = en;
    cpu_memWrEn = we;
    cpu_memAddr = ADDR_W'(addr);
    cpu_dataOut = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_ext(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    ext_req   = req;
    ext_we    = we;
    ext_addr  = ADDR_W'(addr);
    ext_wdata = wd;
  endtask

  // Cycles from now until the DUT grants ext, with stall pulses seen on the way.
  task automatic wait_gnt(output int waited, output int stalls);
    waited = 0;
    stalls = 0;
    do begin
      tick();
      waited++;
      if (obs_stall) stalls++;
    end while (!obs_gnt && waited < 20);
  endtask

  initial begin
    int   waited, stalls, rv_seen;
    logic heavy;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    for (int i = 0; i < 8; i++) begin
      rv_sched[i] = 1'b0;
      rd_sched[i] = '0;
    end
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 0);
    set_ext(1'b0, 1'b0, 0, '0);
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;

    // cpu read with ext idle
    set_cpu(1'b1, 1'b0, 'h05);
    tick();
    set_cpu(1'b0, 1'b0, 0);
    // ext read with cpu idle, then let the data return
    set_ext(1'b1, 1'b0, 'h10, '0);
    tick();
    check_eq("t2_gnt_same_cycle", obs_gnt, 1'b1);
    set_ext(1'b0, 1'b0, 0, '0);
    tick();
    tick();
    check_eq("t2_rvalid_lat", obs_rv, 1'b1);
    tick();

    // ext write starved by a cpu writing every cycle
    set_ext(1'b1, 1'b1, 'h20, {16{8'hAA}});
    set_cpu(1'b1, 1'b1, 'h33);
    wait_gnt(waited, stalls);
    check_eq("t3_wait_cycles", waited, LIMIT + 1);
    check_eq("t3_stall_pulses", stalls, 1);
    set_ext(1'b0, 1'b0, 0, '0);
    tick();
    check_eq("t3_stall_cleared", obs_stall, 1'b0);

    // request dropped after 5 denials, then a fresh request starts over
    set_ext(1'b1, 1'b0, 'h21, '0);
    for (int i = 0; i < 5; i++) tick();
    set_ext(1'b0, 1'b0, 0, '0);
    tick();
    tick();
    set_ext(1'b1, 1'b0, 'h22, '0);
    wait_gnt(waited, stalls);
    check_eq("t6_restart_wait", waited, LIMIT + 1);
    set_ext(1'b0, 1'b0, 0, '0);
    set_cpu(1'b0, 1'b0, 0);
    tick();
    tick();
    tick();

    // ext read granted, then reset before the data returns
    set_ext(1'b1, 1'b0, 'h10, '0);
    tick();
    set_ext(1'b0, 1'b0, 0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_rv) rv_seen++;
    end
    check_eq("t5_no_rvalid_after_reset", rv_seen, 0);

    for (int n = 0; n < 3000; n++) begin
      heavy = ((n / 200) % 2) == 0;
      reset = ($urandom_range(0, 399) == 0);
      set_cpu(heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)) | (int'($urandom_range(0, 8191)) << 8));
      if (ext_req && gnt_e) ext_req = 1'b0;
      if (!ext_req && $urandom_range(0, 2) == 0)
        set_ext(1'b1, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)) | (int'($urandom_range(0, 8191)) << 8),
                {$urandom, $urandom, $urandom, $urandom});
      else if (ext_req && $urandom_range(0, 99) == 0)
        ext_req = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
